lamp_ramp_ctrl: RTL

- Parametrised, registered successor to the combinational active-lamp decoder.
- Samples time code, user light level and room length on a strobe, then computes a target lamp count.
- Ramps the driven lamp count toward the target one lamp per STEP_CYCLES clocks (soft start/stop).
- Sits between the room-settings front end and the lamp driver bank.

---
 rtl/lamp_ramp_if.sv | 29 ++
 rtl/lamp_ramp_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lamp_ramp_if.sv
// lamp_ramp_if
// Purpose : groups the settings-side request signals and the lamp-side status
//           signals of lamp_ramp_ctrl into one bundle.
// Signals : update/tcode/ulight/lenght  - request from the room-settings front end
//           target_lights/active_lights - lamp counts toward the driver bank
//           busy/code_err               - status
// Modports: master (front end / bench), slave (lamp_ramp_ctrl)
interface lamp_ramp_if #(
    parameter int W = 4
);
    logic         update;
    logic [3:0]   tcode;
    logic [W-1:0] ulight;
    logic [W-1:0] lenght;
    logic [W-1:0] target_lights;
    logic [W-1:0] active_lights;
    logic         busy;
    logic         code_err;

    modport master (
        output update, tcode, ulight, lenght,
        input  target_lights, active_lights, busy, code_err
    );

    modport slave (
        input  update, tcode, ulight, lenght,
        output target_lights, active_lights, busy, code_err
    );
endinterface

// File: rtl/lamp_ramp_ctrl.sv
// lamp_ramp_ctrl
// Purpose : samples a time code, user light level and room length on a strobe,
//           decodes a target lamp count and ramps the driven lamp count toward
//           it one lamp every STEP_CYCLES clocks (soft start / soft stop).
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - lamp_ramp_if.slave (update, tcode, ulight, lenght in;
//                   target_lights, active_lights, busy, code_err out)
// Macro   : INSTANT_OFF_EN - when defined, a zero target switches all lamps
//           off on the next clock instead of ramping down.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | active_lights == target_lights, step counter held at 0
// RAMP_UP   | counting toward the next +1 step of active_lights
// RAMP_DOWN | counting toward the next -1 step of active_lights
module lamp_ramp_ctrl #(
    parameter int W           = 4,
    parameter int LEN_DIV     = 4,
    parameter int MAX_LAMPS   = 15,
    parameter int STEP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    lamp_ramp_if.slave  bus
);
    localparam int           CW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
    localparam logic [W-1:0]  MAXL = W'(MAX_LAMPS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_target;
    logic [W-1:0]  r_active, w_active_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_code_err;

    logic [31:0]   w_len_div;
    logic [W-1:0]  w_len_sat;
    logic [W-1:0]  w_user_sat;

    // Divide in 32 bits so LEN_DIV may exceed the W-bit range.
    assign w_len_div  = 32'(bus.lenght) / 32'(LEN_DIV);
    assign w_len_sat  = (w_len_div > 32'(MAX_LAMPS)) ? MAXL : w_len_div[W-1:0];
    assign w_user_sat = (bus.ulight > MAXL) ? MAXL : bus.ulight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target   <= '0;
            r_code_err <= 1'b0;
        end else begin
            r_code_err <= 1'b0;
            if (bus.update) begin
                case (bus.tcode)
                    4'b0000, 4'b0001, 4'b0010: r_target <= '0;
                    4'b0100:                   r_target <= w_len_sat;
                    4'b1000:                   r_target <= w_user_sat;
                    default:                   r_code_err <= 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_active <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_cnt_nxt    = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (r_target > r_active)      w_state_nxt = RAMP_UP;
                else if (r_target < r_active) w_state_nxt = RAMP_DOWN;
            end
            RAMP_UP: begin
                if (r_target == r_active) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_target < r_active) begin
                    w_state_nxt = RAMP_DOWN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_active_nxt = r_active + W'(1);
                    w_cnt_nxt    = '0;
                    if ((r_active + W'(1)) == r_target) w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RAMP_DOWN: begin
                if (r_target == r_active) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_target > r_active) begin
                    w_state_nxt = RAMP_UP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_active_nxt = r_active - W'(1);
                    w_cnt_nxt    = '0;
                    if ((r_active - W'(1)) == r_target) w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
`ifdef INSTANT_OFF_EN
        if (r_target == '0) begin
            w_active_nxt = '0;
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
        end
`endif
    end

    assign bus.target_lights = r_target;
    assign bus.active_lights = r_active;
    assign bus.busy          = (r_active != r_target);
    assign bus.code_err      = r_code_err;
endmodule
